zeowaa_top: RTL and testbench

Board-level demo block for the Zeowaa MAX10 board. It debounces three push-buttons, shifts a pattern across 10 LEDs, and maintains an 8-bit X/Y counter pair steered by the buttons and switches. The X/Y value is shown on a 4-digit multiplexed seven-segment display. All strobe rates are parameterised so simulation can run with 1-bit dividers.

---
 rtl/zeowaa_top_pkg.sv | 23 ++
 rtl/zeowaa_top_debounce.sv | 47 ++++
 rtl/zeowaa_top_strobe_gen.sv | 27 ++
 rtl/zeowaa_top.sv | 125 ++++++++++++
 tb/tb_zeowaa_top.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/zeowaa_top_pkg.sv
// zeowaa_top_pkg
//   Shared definitions for the Zeowaa MAX10 demo block: seven-segment glyph
//   table (active-low, bit 7 = a ... bit 1 = g, bit 0 = dp), blank patterns
//   and the hex-to-glyph lookup used by the display multiplexer.
package zeowaa_top_pkg;

  typedef logic [7:0] glyph_t;
  typedef logic [1:0] digit_idx_t;

  localparam glyph_t     seg_blank = 8'hFF;
  localparam logic [3:0] digit_off = 4'b1111;

  // Hex glyphs 0..F, segments active-low, decimal point always off.
  localparam glyph_t seg_glyph [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  function automatic glyph_t hex_to_seg(input logic [3:0] nibble);
    return seg_glyph[nibble];
  endfunction

endpackage

// File: rtl/zeowaa_top_debounce.sv
// zeowaa_top_debounce
//   One push-button: 2-FF synchroniser followed by a stability counter.
//   The counter clears whenever the synchronised level changes; once it has
//   saturated at all-ones the (stable) level is copied to the output.
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-low
//   key_raw   in   raw button level, asynchronous to clk
//   debounced out  filtered level (1 = released after reset)
module zeowaa_top_debounce #(
  parameter int depth = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic debounced
);

  logic             sync_1;
  logic             sync_2;
  logic             sync_prev;
  logic [depth-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Synchroniser starts at the released level so no false press follows reset.
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      sync_prev <= 1'b1;
      cnt       <= '0;
      debounced <= 1'b1;
    end else begin
      sync_1    <= key_raw;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      if (sync_2 != sync_prev) begin
        cnt <= '0;
      end else if (cnt == '1) begin
        // Only copy a level that has been seen unchanged for the full count.
        debounced <= sync_prev;
      end else begin
        cnt <= cnt + depth'(1);
      end
    end
  end

endmodule

// File: rtl/zeowaa_top_strobe_gen.sv
// zeowaa_top_strobe_gen
//   Free-running divider. strobe is high for one cycle whenever the counter
//   is all-ones: first pulse 2^width-1 cycles after reset, then every 2^width.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-low
//   strobe out  one-cycle pulse
module zeowaa_top_strobe_gen #(
  parameter int width = 1
) (
  input  logic clk,
  input  logic reset,
  output logic strobe
);

  logic [width-1:0] cnt;

  // NOTE: clocked state is always assigned with <= so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt + width'(1);
  end

  assign strobe = (cnt == '1);

endmodule

// File: rtl/zeowaa_top.sv
// zeowaa_top
//   Zeowaa MAX10 board demo: debounced buttons drive a 10-LED shifter and an
//   8-bit X/Y counter pair; {x, y} is shown on a 4-digit multiplexed display.
// Ports:
//   clk       in   system clock (50 MHz on board)
//   reset     in   asynchronous, active-low
//   key[2:0]  in   push-buttons, active-low, asynchronous
//   sw[9:0]   in   slide switches, static levels (sw[9] shift dir, sw[8] blank,
//                  sw[1]/sw[0] y/x count down)
//   led[9:0]  out  LEDs, active-high
//   abcdefgh  out  segments a..g, dp (bit 7 = a), active-low
//   digit     out  digit enables, active-low one-hot, bit 0 = rightmost
module zeowaa_top
  import zeowaa_top_pkg::*;
#(
  parameter int debounce_depth                    = 16,
  parameter int shift_strobe_width                = 23,
  parameter int seven_segment_strobe_width        = 10,
  parameter int strobe_to_update_xy_counter_width = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key,
  input  logic [9:0] sw,
  output logic [9:0] led,
  output logic [7:0] abcdefgh,
  output logic [3:0] digit
);

  logic [2:0] debounced;
  logic [2:0] pressed;
  logic       shift_strobe;
  logic       seg_strobe;
  logic       xy_strobe;
  logic [7:0] x;
  logic [7:0] y;
  digit_idx_t idx;
  logic [3:0] nibble;

  // Switches 2..7 have no function in this demo.
  logic unused_sw;
  assign unused_sw = &{1'b0, sw[7:2]};

  for (genvar i = 0; i < 3; i++) begin : g_key
    zeowaa_top_debounce #(.depth(debounce_depth)) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (key[i]),
      .debounced (debounced[i])
    );
  end

  assign pressed = ~debounced;

  zeowaa_top_strobe_gen #(.width(shift_strobe_width)) u_shift_strobe (
    .clk    (clk),
    .reset  (reset),
    .strobe (shift_strobe)
  );

  zeowaa_top_strobe_gen #(.width(seven_segment_strobe_width)) u_seg_strobe (
    .clk    (clk),
    .reset  (reset),
    .strobe (seg_strobe)
  );

  zeowaa_top_strobe_gen #(.width(strobe_to_update_xy_counter_width)) u_xy_strobe (
    .clk    (clk),
    .reset  (reset),
    .strobe (xy_strobe)
  );

  // LED shifter: sw[9] selects right shift, pressed[0] is the fill bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= '0;
    end else if (shift_strobe) begin
      if (sw[9]) led <= {pressed[0], led[9:1]};
      else       led <= {led[8:0], pressed[0]};
    end
  end

  // X/Y counters wrap naturally through 8-bit arithmetic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (xy_strobe) begin
      if (pressed[1]) x <= sw[0] ? x - 8'd1 : x + 8'd1;
      if (pressed[2]) y <= sw[1] ? y - 8'd1 : y + 8'd1;
    end
  end

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it holding a value (no latch).
  always_comb begin
    nibble = y[3:0];
    case (idx)
      2'd1:    nibble = y[7:4];
      2'd2:    nibble = x[3:0];
      2'd3:    nibble = x[7:4];
      default: nibble = y[3:0];
    endcase
  end

  // Display outputs are registered from the current index, so they follow
  // an index change one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      digit    <= digit_off;
      abcdefgh <= seg_blank;
    end else begin
      if (seg_strobe) idx <= idx + 2'd1;
      if (sw[8]) begin
        digit    <= digit_off;
        abcdefgh <= seg_blank;
      end else begin
        digit    <= ~(4'b0001 << idx);
        abcdefgh <= hex_to_seg(nibble);
      end
    end
  end

endmodule

// File: tb/tb_zeowaa_top.sv
// tb_zeowaa_top
//   Directed bench for zeowaa_top with all dividers at width 1: every strobe
//   fires on even cycles after reset release, a key needs 3 stable cycles and
//   reaches 'pressed' 5 cycles after the pin changes.
module tb_zeowaa_top;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] key = 3'b111;
  logic [9:0] sw = '0;
  logic [9:0] led;
  logic [7:0] abcdefgh;
  logic [3:0] digit;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  zeowaa_top #(
    .debounce_depth                    (1),
    .shift_strobe_width                (1),
    .seven_segment_strobe_width        (1),
    .strobe_to_update_xy_counter_width (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key      (key),
    .sw       (sw),
    .led      (led),
    .abcdefgh (abcdefgh),
    .digit    (digit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance n rising edges and settle 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Put the next edge at an odd count, so a key pressed now first reaches
  // the counters on an odd edge (updates happen on even edges).
  task automatic align_odd();
    if (cyc % 2 == 0) tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    key   = 3'b111;
    sw    = '0;
    tick(2);
    reset = 1'b1;
    cyc   = 0;
  endtask

  // Reference glyphs written active-high as segments a..g, then inverted.
  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'b1111110;  4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;  4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;  4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;  4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;  4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;  4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;  4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;  default: seg = 7'b1000111;
    endcase
    return {~seg, 1'b1};
  endfunction

  // Watch the multiplexed display for 10 cycles; return {seen_mask, value}
  // where value is the 16-bit number decoded from the four digit positions.
  task automatic read_display(output logic [19:0] r);
    logic [3:0]  mask;
    logic [15:0] v;
    logic [3:0]  sel;
    mask = '0;
    v    = '0;
    repeat (10) begin
      tick(1);
      for (int p = 0; p < 4; p++) begin
        sel = 4'b0001 << p;
        if (digit == ~sel) begin
          for (int n = 0; n < 16; n++) begin
            if (abcdefgh == glyph(4'(n))) begin
              v[p*4 +: 4] = 4'(n);
              mask[p]     = 1'b1;
            end
          end
        end
      end
    end
    r = {mask, v};
  endtask

  initial begin
    logic [19:0] disp;
    logic        found;
    int          bad;

    // Reset values, then first display strobe.
    reset = 1'b0;
    tick(2);
    check("rst_led", 32'(led), 32'h000);
    check("rst_digit", 32'(digit), 32'hF);
    check("rst_seg", 32'(abcdefgh), 32'hFF);
    reset = 1'b1;
    cyc   = 0;
    check("rel_digit", 32'(digit), 32'hF);
    tick(2);
    check("strobe1_digit", 32'(digit), 32'hE);
    check("strobe1_seg", 32'(abcdefgh), 32'h03);
    tick(1);
    check("strobe1_next_digit", 32'(digit), 32'hD);

    // One-cycle glitch on key[0] must never reach the LEDs.
    do_reset();
    tick(3);
    key[0] = 1'b0;
    tick(1);
    key[0] = 1'b1;
    tick(20);
    check("glitch_led", 32'(led), 32'h000);

    // Held press reaches the LED fill bit within a few cycles.
    key[0] = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1);
      if (led != 10'h000) found = 1'b1;
    end
    check("press_latency", 32'(found), 32'h1);
    tick(6);
    key[0] = 1'b1;

    // LED shift left with key held fills all ones.
    do_reset();
    key[0] = 1'b0;
    tick(30);
    check("led_fill", 32'(led), 32'h3FF);
    // Release and shift right: ones keep entering until the release is seen.
    key[0] = 1'b1;
    sw[9]  = 1'b1;
    found  = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1);
      if (led != 10'h3FF) found = 1'b1;
    end
    check("led_right1", 32'(led), 32'h1FF);
    tick(4);
    check("led_right3", 32'(led), 32'h07F);
    sw[9] = 1'b0;
    tick(2);
    check("led_left0", 32'(led), 32'h0FE);

    // Asynchronous reset mid-operation clears at once, before any edge.
    reset = 1'b0;
    #2;
    check("midrst_led", 32'(led), 32'h000);
    check("midrst_digit", 32'(digit), 32'hF);
    check("midrst_seg", 32'(abcdefgh), 32'hFF);

    // X wraps down from 0 in exactly one xy strobe.
    do_reset();
    align_odd();
    key[1] = 1'b0;
    sw[0]  = 1'b1;
    tick(3);
    key[1] = 1'b1;
    tick(6);
    read_display(disp);
    check("x_wrap_disp", 32'(disp), 32'hF_FF00);

    // Y wraps down likewise.
    do_reset();
    align_odd();
    key[2] = 1'b0;
    sw[1]  = 1'b1;
    tick(3);
    key[2] = 1'b1;
    tick(6);
    read_display(disp);
    check("y_wrap_disp", 32'(disp), 32'hF_00FF);

    // Both counters up for three strobes.
    do_reset();
    align_odd();
    key = 3'b001;
    tick(6);
    key = 3'b111;
    tick(6);
    read_display(disp);
    check("xy_up3_disp", 32'(disp), 32'hF_0303);

    // Then x down, y up for two strobes.
    align_odd();
    key = 3'b001;
    sw  = 10'b00_0000_0001;
    tick(4);
    key = 3'b111;
    tick(6);
    sw  = '0;
    read_display(disp);
    check("x_dn_y_up_disp", 32'(disp), 32'hF_0105);

    // Blanking.
    sw[8] = 1'b1;
    tick(2);
    check("blank_digit", 32'(digit), 32'hF);
    sw[8] = 1'b0;
    tick(2);
    check("unblank_onehot", 32'($onehot(~digit)), 32'h1);

    // Random soak: no unknowns, digit always one-hot-low or all off.
    do_reset();
    bad = 0;
    for (int i = 0; i < 20000; i++) begin
      if (i % 4 == 0) begin
        key = 3'($urandom);
        sw  = 10'($urandom);
      end
      tick(1);
      if ($isunknown({led, abcdefgh, digit})) bad++;
      if (!(digit == 4'b1111 || $onehot(~digit))) bad++;
    end
    check("soak_bad", 32'(bad), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
